// File: rtl/fifo_umbral_fwft_pkg.sv
// Shared definitions for the thresholded FWFT FIFO and its bench.
//   MEM_SIZE_DEF / WORD_SIZE_DEF : default geometry
//   cnt_bits()                   : width of count/threshold ports for a depth
//   fifo_op_e                    : per-edge accepted operation, {pop_ok, push_ok}
package fifo_umbral_fwft_pkg;

    localparam int MEM_SIZE_DEF  = 4;
    localparam int WORD_SIZE_DEF = 6;

    // Count must reach MEM_SIZE itself, hence one bit beyond the pointer.
    function automatic int cnt_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_umbral_fwft_memoria_dp.sv
// Simple dual-port register array: synchronous write, asynchronous read.
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : combinational read data
// Contents are never reset.
module memoria_dp #(
    parameter int WORD_SIZE = 6,
    parameter int PTR_L     = 2
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [PTR_L-1:0]     wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic [PTR_L-1:0]     rd_addr,
    output logic [WORD_SIZE-1:0] rd_data
);

    logic [WORD_SIZE-1:0] mem [0:(1 << PTR_L) - 1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_umbral_fwft.sv
// Parametrised synchronous FIFO with occupancy count, programmable
// almost-empty/almost-full thresholds, sticky overflow/underflow errors and
// a selectable first-word-fall-through read mode.
//   clk, reset_L            : clock (rising edge), async active-low reset
//   fifo_data_in, fifo_wr   : push data / request
//   fifo_rd                 : pop request
//   empty_threshold         : almost_empty when count <= this
//   full_threshold          : almost_full when count >= this
//   err_clr                 : clears sticky error flags
//   fifo_data_out           : read data (registered, or head word if FWFT)
//   data_valid              : fifo_data_out carries a popped / head word
//   fifo_count              : occupancy 0..MEM_SIZE
//   fifo_empty, fifo_full   : occupancy flags
//   almost_empty/almost_full: threshold flags
//   err_overflow/underflow  : sticky rejected push / pop
//   error                   : OR of both error flags
module fifo_umbral_fwft
    import fifo_umbral_fwft_pkg::*;
#(
    parameter int  MEM_SIZE  = MEM_SIZE_DEF,
    parameter int  WORD_SIZE = WORD_SIZE_DEF,
    parameter int  FWFT      = 0,
    localparam int PTR_L     = $clog2(MEM_SIZE),
    localparam int CNT_L     = cnt_bits(MEM_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic [WORD_SIZE-1:0] fifo_data_in,
    input  logic                 fifo_wr,
    input  logic                 fifo_rd,
    input  logic [CNT_L-1:0]     empty_threshold,
    input  logic [CNT_L-1:0]     full_threshold,
    input  logic                 err_clr,
    output logic [WORD_SIZE-1:0] fifo_data_out,
    output logic                 data_valid,
    output logic [CNT_L-1:0]     fifo_count,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic                 err_overflow,
    output logic                 err_underflow,
    output logic                 error
);

    localparam logic [CNT_L-1:0] FULL_CNT = CNT_L'(MEM_SIZE);

    logic [PTR_L-1:0]     wr_ptr;
    logic [PTR_L-1:0]     rd_ptr;
    logic [CNT_L-1:0]     count;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 push_ok;
    logic                 pop_ok;
    logic                 ovf_set;
    logic                 unf_set;
    fifo_op_e             op;

    // A full FIFO still takes a push when a pop frees the slot at the same edge.
    assign push_ok = fifo_wr & (~fifo_full | fifo_rd);
    assign pop_ok  = fifo_rd & ~fifo_empty;
    assign ovf_set = fifo_wr & fifo_full & ~fifo_rd;
    assign unf_set = fifo_rd & fifo_empty;
    assign op      = fifo_op_e'({pop_ok, push_ok});

    memoria_dp #(
        .WORD_SIZE (WORD_SIZE),
        .PTR_L     (PTR_L)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (fifo_data_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_L'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_L'(1);
            case (op)
                OP_PUSH: count <= count + CNT_L'(1);
                OP_POP:  count <= count - CNT_L'(1);
                default: count <= count;
            endcase
        end
    end

    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            err_overflow  <= ovf_set | (err_overflow  & ~err_clr);
            err_underflow <= unf_set | (err_underflow & ~err_clr);
        end
    end

    assign fifo_count   = count;
    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == FULL_CNT);
    assign almost_empty = (count <= empty_threshold);
    assign almost_full  = (count >= full_threshold);
    assign error        = err_overflow | err_underflow;

    generate
        if (FWFT != 0) begin : g_fwft
            assign fifo_data_out = rd_data;
            assign data_valid    = ~fifo_empty;
        end else begin : g_reg
            logic [WORD_SIZE-1:0] dout_q;
            logic                 valid_q;

            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= pop_ok;
                    if (pop_ok) dout_q <= rd_data;
                end
            end

            assign fifo_data_out = dout_q;
            assign data_valid    = valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_umbral_fwft.sv
module tb_fifo_umbral_fwft;
    import fifo_umbral_fwft_pkg::*;

    localparam int MEM   = MEM_SIZE_DEF;
    localparam int W     = WORD_SIZE_DEF;
    localparam int CNT_L = cnt_bits(MEM_SIZE_DEF);

    logic             clk = 1'b0;
    logic             reset_L;
    logic [W-1:0]     fifo_data_in;
    logic             fifo_wr, fifo_rd, err_clr;
    logic [CNT_L-1:0] empty_threshold, full_threshold;

    logic [W-1:0]     dout0, dout1;
    logic             dv0, dv1;
    logic [CNT_L-1:0] cnt0, cnt1;
    logic             emp0, emp1, ful0, ful1, ae0, ae1, af0, af1;
    logic             ovf0, ovf1, unf0, unf1, err0, err1;

    int errors = 0;
    int checks = 0;

    // Reference model: occupancy is the queue itself.
    logic [W-1:0] q[$];
    logic [W-1:0] m_out;
    logic         m_valid, m_ovf, m_unf;

    always #5 clk = ~clk;

    fifo_umbral_fwft #(.MEM_SIZE(MEM), .WORD_SIZE(W), .FWFT(0)) dut0 (
        .clk(clk), .reset_L(reset_L), .fifo_data_in(fifo_data_in),
        .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
        .empty_threshold(empty_threshold), .full_threshold(full_threshold),
        .err_clr(err_clr), .fifo_data_out(dout0), .data_valid(dv0),
        .fifo_count(cnt0), .fifo_empty(emp0), .fifo_full(ful0),
        .almost_empty(ae0), .almost_full(af0),
        .err_overflow(ovf0), .err_underflow(unf0), .error(err0)
    );

    fifo_umbral_fwft #(.MEM_SIZE(MEM), .WORD_SIZE(W), .FWFT(1)) dut1 (
        .clk(clk), .reset_L(reset_L), .fifo_data_in(fifo_data_in),
        .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
        .empty_threshold(empty_threshold), .full_threshold(full_threshold),
        .err_clr(err_clr), .fifo_data_out(dout1), .data_valid(dv1),
        .fifo_count(cnt1), .fifo_empty(emp1), .fifo_full(ful1),
        .almost_empty(ae1), .almost_full(af1),
        .err_overflow(ovf1), .err_underflow(unf1), .error(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_out   = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic model_edge();
        int  sz   = q.size();
        bit  full = (sz == MEM);
        bit  emp  = (sz == 0);
        bit  push = fifo_wr && (!full || fifo_rd);
        bit  pop  = fifo_rd && !emp;
        bit  ovf_ev = fifo_wr && full && !fifo_rd;
        bit  unf_ev = fifo_rd && emp;
        m_valid = pop;
        if (pop) m_out = q.pop_front();
        if (push) q.push_back(fifo_data_in);
        m_ovf = ovf_ev ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
        m_unf = unf_ev ? 1'b1 : (err_clr ? 1'b0 : m_unf);
    endtask

    task automatic check_all();
        int sz = q.size();
        chk("count",         32'(cnt0), 32'(sz));
        chk("empty",         32'(emp0), 32'(sz == 0));
        chk("full",          32'(ful0), 32'(sz == MEM));
        chk("almost_empty",  32'(ae0),  32'(sz <= int'(empty_threshold)));
        chk("almost_full",   32'(af0),  32'(sz >= int'(full_threshold)));
        chk("err_overflow",  32'(ovf0), 32'(m_ovf));
        chk("err_underflow", 32'(unf0), 32'(m_unf));
        chk("error",         32'(err0), 32'(m_ovf | m_unf));
        chk("data_valid",    32'(dv0),  32'(m_valid));
        chk("data_out",      32'(dout0), 32'(m_out));
        chk("fwft_count",    32'(cnt1), 32'(sz));
        chk("fwft_valid",    32'(dv1),  32'(sz != 0));
        chk("fwft_error",    32'(err1), 32'(m_ovf | m_unf));
        if (sz != 0) chk("fwft_head", 32'(dout1), 32'(q[0]));
    endtask

    task automatic step(input logic wr, input logic rd, input logic [W-1:0] d, input logic clr);
        fifo_wr      = wr;
        fifo_rd      = rd;
        fifo_data_in = d;
        err_clr      = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Reset asserted between edges: outputs must clear before any clock.
    task automatic async_reset();
        #2;
        reset_L = 1'b0;
        model_reset();
        #1;
        check_all();
        fifo_wr = 1'b0;
        fifo_rd = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset_L = 1'b1;
    endtask

    initial begin
        reset_L         = 1'b0;
        fifo_wr         = 1'b0;
        fifo_rd         = 1'b0;
        err_clr         = 1'b0;
        fifo_data_in    = '0;
        empty_threshold = CNT_L'(1);
        full_threshold  = CNT_L'(3);
        model_reset();
        #3;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        reset_L = 1'b1;

        // Fill to three, threshold crossings
        step(1, 0, 6'h11, 0);
        step(1, 0, 6'h22, 0);
        step(1, 0, 6'h33, 0);

        // Fill, then overflow held for two cycles, then clear
        step(1, 0, 6'h04, 0);
        step(1, 0, 6'h15, 0);
        step(1, 0, 6'h26, 0);
        step(0, 0, 6'h00, 0);
        step(0, 0, 6'h00, 1);

        // Full, simultaneous read/write with random data
        for (int i = 0; i < 10; i++) step(1, 1, W'($urandom), 0);

        // Drain
        for (int i = 0; i < 4; i++) step(0, 1, 6'h00, 0);
        step(0, 0, 6'h00, 0);

        // Empty: read+write -> underflow but write accepted
        step(1, 1, 6'h2A, 0);
        step(0, 1, 6'h00, 0);
        // Underflow again with clear in same cycle: set wins
        step(0, 1, 6'h00, 1);
        step(0, 0, 6'h00, 1);

        // Word into empty FIFO: visible next cycle in FWFT mode
        step(1, 0, 6'h05, 0);
        step(0, 0, 6'h00, 0);
        step(0, 1, 6'h00, 0);

        // Threshold edge configurations, combinational effect
        step(1, 0, 6'h31, 0);
        empty_threshold = CNT_L'(MEM);
        full_threshold  = '0;
        #1;
        check_all();
        empty_threshold = CNT_L'(7);
        full_threshold  = CNT_L'(MEM);
        #1;
        check_all();

        // Randomized traffic with occasional threshold changes
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                empty_threshold = CNT_L'($urandom_range(0, 7));
                full_threshold  = CNT_L'($urandom_range(0, 7));
            end
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 W'($urandom), 1'($urandom_range(0, 7) == 0));
        end

        // Mid-operation asynchronous reset discards data
        empty_threshold = CNT_L'(1);
        full_threshold  = CNT_L'(3);
        step(0, 0, 6'h00, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 6'h00, 0);
        step(1, 0, 6'h0A, 1);
        step(1, 0, 6'h0B, 0);
        step(1, 0, 6'h0C, 0);
        async_reset();
        step(0, 1, 6'h00, 0);
        step(0, 0, 6'h00, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
